// File: rtl/alu_exec.sv
// Registered execute stage of the 4-bit ALU datapath: adds the conditioned operands
// through a two-entry valid/ready pipeline and keeps a transfer counter and sticky overflow.
module alu_exec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] AMod,
  input  logic [WIDTH-1:0] BMod,
  input  logic [2:0]       Op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Result,
  output logic             C,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       op_count,
  output logic             sticky_v,
  input  logic             clr_sticky
);

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic             s1_valid;
  logic             s2_valid;

  logic             accept;
  logic             advance;
  logic             out_xfer;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             c_d;
  logic             z_d;
  logic             n_d;
  logic             v_d;

  // in_ready looks at out_ready directly so a full pipe still streams at one op per cycle.
  assign in_ready  = !reset && (!s1_valid || !s2_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign advance   = s1_valid && (!s2_valid || out_ready);
  assign out_xfer  = s2_valid && out_ready;
  assign out_valid = s2_valid;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    sum   = '0;
    res_d = '0;
    c_d   = 1'b0;
    z_d   = 1'b0;
    n_d   = 1'b0;
    v_d   = 1'b0;
    sum   = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
    res_d = sum[WIDTH-1:0];
    c_d   = sum[WIDTH];
    z_d   = (res_d == '0);
    n_d   = res_d[WIDTH-1];
    v_d   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (res_d[WIDTH-1] != s1_a[WIDTH-1]);
  end

  // NOTE: s1 operand registers carry no reset; s1_valid alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a   <= AMod;
      s1_b   <= BMod;
      s1_cin <= (Op == 3'b001);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      Result   <= '0;
      C        <= 1'b0;
      Z        <= 1'b0;
      N        <= 1'b0;
      V        <= 1'b0;
      op_count <= '0;
      sticky_v <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      // Output registers only load on advance, so they hold steady under backpressure.
      if (advance) begin
        s2_valid <= 1'b1;
        Result   <= res_d;
        C        <= c_d;
        Z        <= z_d;
        N        <= n_d;
        V        <= v_d;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end

      if (out_xfer) begin
        op_count <= op_count + 8'd1;
      end

      // A same-cycle overflow transfer beats the clear request.
      if (out_xfer && V) begin
        sticky_v <= 1'b1;
      end else if (clr_sticky) begin
        sticky_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vectors, backpressure/reset sequences and a
// randomized phase, all checked against an arithmetic reference model with a scoreboard queue.
module tb_alu_exec;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } vec_t;

  typedef struct {
    logic [3:0] r;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    int         acc;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] AMod;
  logic [3:0] BMod;
  logic [2:0] Op;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Result;
  logic       C;
  logic       Z;
  logic       N;
  logic       V;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] op_count;
  logic       sticky_v;
  logic       clr_sticky;

  int total = 0;
  int bad   = 0;

  // Scoreboard state
  ent_t       q[$];
  int         cyc      = 0;
  int         m_cnt    = 0;
  logic       m_sticky = 1'b0;
  logic       mon_en   = 1'b0;

  vec_t tbl[7];

  alu_exec #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .AMod       (AMod),
    .BMod       (BMod),
    .Op         (Op),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Result     (Result),
    .C          (C),
    .Z          (Z),
    .N          (N),
    .V          (V),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_count   (op_count),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned sum for result/carry, signed range test for overflow.
  function automatic ent_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    ent_t e;
    int   ua;
    int   ub;
    int   cin;
    int   s;
    int   sa;
    int   sb;
    int   ss;
    ua   = int'(a);
    ub   = int'(b);
    cin  = (op == 3'b001) ? 1 : 0;
    s    = ua + ub + cin;
    e.r  = 4'(s % 16);
    e.c  = (s > 15);
    e.z  = ((s % 16) == 0);
    e.n  = ((s % 16) >= 8);
    sa   = (ua >= 8) ? ua - 16 : ua;
    sb   = (ub >= 8) ? ub - 16 : ub;
    ss   = sa + sb + cin;
    e.v  = (ss > 7) || (ss < -8);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compare everything against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ovalid;
      logic exp_iready;
      logic xfer;
      ent_t e;
      cyc++;
      exp_ovalid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
      exp_iready = !reset && ((q.size() < 2) || out_ready);
      check("out_valid", 32'(out_valid), 32'(exp_ovalid));
      check("in_ready", 32'(in_ready), 32'(exp_iready));
      check("op_count", 32'(op_count), 32'(m_cnt));
      check("sticky_v", 32'(sticky_v), 32'(m_sticky));
      if (out_valid && (q.size() > 0)) begin
        check("result_flags", 32'({Result, C, Z, N, V}),
              32'({q[0].r, q[0].c, q[0].z, q[0].n, q[0].v}));
      end
      if (reset) begin
        q.delete();
        m_cnt    = 0;
        m_sticky = 1'b0;
      end else begin
        xfer = exp_ovalid && out_ready;
        if (xfer && q[0].v) m_sticky = 1'b1;
        else if (clr_sticky) m_sticky = 1'b0;
        if (xfer) begin
          m_cnt = (m_cnt + 1) % 256;
          void'(q.pop_front());
        end
        if (in_valid && exp_iready) begin
          e     = model(AMod, BMod, Op);
          e.acc = cyc;
          q.push_back(e);
        end
      end
    end
  end

  // Present one operation and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int waited;
    waited   = 0;
    AMod     = a;
    BMod     = b;
    Op       = op;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: in_ready got 0 want 1 after %0d cycles", waited);
        @(posedge clk);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'h7, 4'h1, 3'b010, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{4'hF, 4'h1, 3'b010, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{4'hC, 4'h0, 3'b001, 4'hD, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'h8, 4'h8, 3'b010, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{4'h7, 4'h7, 3'b001, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{4'h0, 4'h0, 3'b000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'hF, 4'hF, 3'b001, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};

    reset      = 1'b1;
    AMod       = '0;
    BMod       = '0;
    Op         = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;

    // Reset state
    tick(2);
    mon_en = 1'b1;
    check("reset_outputs", 32'({Result, C, Z, N, V, out_valid, sticky_v}), 32'(0));
    check("reset_count", 32'(op_count), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(0));
    reset = 1'b0;
    tick(1);

    // Directed vectors, one at a time, two-edge latency
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].op);
      @(posedge clk);
      #1;
      check("vec_valid", 32'(out_valid), 32'(1));
      check("vec_result", 32'({Result, C, Z, N, V}),
            32'({tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].n, tbl[i].v}));
    end
    check("vec_sticky", 32'(sticky_v), 32'(1));
    tick(3);

    // Backpressure: two absorbed, third refused, head result held
    out_ready = 1'b0;
    send(4'h0, 4'h1, 3'b010);
    send(4'h0, 4'h2, 3'b010);
    AMod     = 4'h0;
    BMod     = 4'h3;
    Op       = 3'b010;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_hold", 32'({out_valid, Result}), 32'({1'b1, 4'h1}));
      tick(1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'(1));
    send(4'h0, 4'h3, 3'b010);
    tick(4);

    // Streaming: back-to-back random operations
    for (int i = 0; i < 20; i++) begin
      send(4'($urandom), 4'($urandom), 3'($urandom));
    end
    tick(3);

    // Sticky: clear in the same cycle as a V=1 transfer loses, clear alone wins
    out_ready = 1'b0;
    send(4'h7, 4'h1, 3'b010);
    tick(1);
    check("sticky_pending", 32'({out_valid, V}), 32'({1'b1, 1'b1}));
    clr_sticky = 1'b1;
    out_ready  = 1'b1;
    tick(1);
    check("sticky_set_wins", 32'(sticky_v), 32'(1));
    tick(1);
    check("sticky_cleared", 32'(sticky_v), 32'(0));
    clr_sticky = 1'b0;

    // Counter wrap: 256 transfers from reset return op_count to 0
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send(4'($urandom), 4'($urandom), 3'($urandom));
    end
    tick(3);
    check("count_wrap", 32'(op_count), 32'(0));

    // Randomized traffic with random backpressure and clears
    for (int i = 0; i < 200; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      AMod       = 4'($urandom);
      BMod       = 4'($urandom);
      Op         = 3'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    tick(4);

    // Reset with both stages full: nothing emitted, clean restart
    send(4'h7, 4'h1, 3'b010);
    tick(2);
    out_ready = 1'b0;
    send(4'h1, 4'h1, 3'b010);
    send(4'h2, 4'h2, 3'b010);
    check("full_before_reset", 32'({out_valid, in_ready, sticky_v}), 32'({1'b1, 1'b0, 1'b1}));
    reset = 1'b1;
    #1;
    check("reset_in_ready_comb", 32'(in_ready), 32'(0));
    tick(1);
    for (int i = 0; i < 2; i++) begin
      check("midreset_state", 32'({out_valid, in_ready, sticky_v, op_count}), 32'(0));
      tick(1);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    send(4'h3, 4'h4, 3'b001);
    check("restart_latency_s1", 32'(out_valid), 32'(0));
    tick(1);
    check("restart_valid", 32'(out_valid), 32'(1));
    check("restart_result", 32'({Result, C, Z, N, V}), 32'({4'h8, 1'b0, 1'b0, 1'b1, 1'b1}));
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
